// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: circular byte FIFO feeding an 8N1 UART transmitter.
// Queued bytes are framed back-to-back on a registered, idle-high txd.
module uart_tx_fifo #(
  parameter int clock_freq = 50000000,
  parameter int baud_rate  = 115200,
  parameter int depth_log2 = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [7:0]            data_in,
  input  logic                  data_valid,
  output logic                  data_ready,
  input  logic                  rewind,
  output logic                  txd,
  output logic                  busy,
  output logic [depth_log2:0]   fifo_count
);

  localparam int DIV   = clock_freq / baud_rate;
  localparam int DEPTH = 2 ** depth_log2;
  localparam int CW    = depth_log2 + 1;
  localparam int TW    = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [TW-1:0]         BIT_LAST   = TW'(DIV - 1);
  localparam logic [TW-1:0]         TMR_ONE    = TW'(1'b1);
  localparam logic [CW-1:0]         FULL_COUNT = CW'(DEPTH);
  localparam logic [CW-1:0]         CNT_ONE    = CW'(1'b1);
  localparam logic [depth_log2-1:0] PTR_ONE    = depth_log2'(1'b1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  tx_state_t             state_r;
  tx_state_t             state_next_s;
  logic [7:0]            fifo_mem_r [DEPTH];
  logic [depth_log2-1:0] wr_ptr_r;
  logic [depth_log2-1:0] rd_ptr_r;
  logic [CW-1:0]         count_r;
  logic [TW-1:0]         timer_r;
  logic [2:0]            bit_idx_r;
  logic [7:0]            shift_r;
  logic                  txd_r;

  logic push_s;
  logic pop_s;
  logic bit_done_s;
  logic txd_bit_s;
  logic fifo_empty_s;
  logic flush_s;

  assign flush_s      = reset || rewind;
  assign fifo_empty_s = (count_r == {CW{1'b0}});
  assign bit_done_s   = (timer_r == BIT_LAST);
  assign data_ready   = !reset && !rewind && (count_r < FULL_COUNT);
  assign push_s       = data_valid && data_ready;

  assign txd        = txd_r;
  assign fifo_count = count_r;
  assign busy       = !((state_r == IDLE) && fifo_empty_s);

  // Transmit state register; reset and rewind both return to IDLE.
  always_ff @(posedge clock) begin
    if (flush_s) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic; STOP chains straight into START when a byte is queued.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (!fifo_empty_s) begin
          state_next_s = START;
        end else begin
          state_next_s = IDLE;
        end
      end
      START: begin
        if (bit_done_s) begin
          state_next_s = DATA;
        end else begin
          state_next_s = START;
        end
      end
      DATA: begin
        if (bit_done_s && (bit_idx_r == 3'd7)) begin
          state_next_s = STOP;
        end else begin
          state_next_s = DATA;
        end
      end
      STOP: begin
        if (bit_done_s && !fifo_empty_s) begin
          state_next_s = START;
        end else if (bit_done_s) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = STOP;
        end
      end
      default: state_next_s = IDLE;
    endcase
  end

  // FSM outputs: line level for the current bit and the FIFO pop strobe.
  always_comb begin
    txd_bit_s = 1'b1;
    pop_s     = 1'b0;
    case (state_r)
      IDLE: begin
        txd_bit_s = 1'b1;
        pop_s     = !fifo_empty_s;
      end
      START: begin
        txd_bit_s = 1'b0;
        pop_s     = 1'b0;
      end
      DATA: begin
        txd_bit_s = shift_r[bit_idx_r];
        pop_s     = 1'b0;
      end
      STOP: begin
        txd_bit_s = 1'b1;
        pop_s     = bit_done_s && !fifo_empty_s;
      end
      default: begin
        txd_bit_s = 1'b1;
        pop_s     = 1'b0;
      end
    endcase
  end

  // Bit timer and data bit index; the timer restarts on every pop and bit boundary.
  always_ff @(posedge clock) begin
    if (flush_s) begin
      timer_r   <= {TW{1'b0}};
      bit_idx_r <= 3'd0;
    end else begin
      if (pop_s || (state_r == IDLE) || bit_done_s) begin
        timer_r <= {TW{1'b0}};
      end else begin
        timer_r <= timer_r + TMR_ONE;
      end
      if ((state_r == DATA) && bit_done_s) begin
        bit_idx_r <= bit_idx_r + 3'd1;
      end else if (state_r != DATA) begin
        bit_idx_r <= 3'd0;
      end
    end
  end

  // Frame holding register, loaded from the FIFO head on pop.
  always_ff @(posedge clock) begin
    if (reset) begin
      shift_r <= 8'h00;
    end else if (pop_s && !rewind) begin
      shift_r <= fifo_mem_r[rd_ptr_r];
    end
  end

  // FIFO pointers and occupancy; a simultaneous push and pop cancel out.
  always_ff @(posedge clock) begin
    if (flush_s) begin
      wr_ptr_r <= {depth_log2{1'b0}};
      rd_ptr_r <= {depth_log2{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  // FIFO storage; push is already blocked during reset and rewind.
  always_ff @(posedge clock) begin
    if (push_s) begin
      fifo_mem_r[wr_ptr_r] <= data_in;
    end
  end

  // Registered serial line, lagging the FSM by one clock; forced idle on flush.
  always_ff @(posedge clock) begin
    if (flush_s) begin
      txd_r <= 1'b1;
    end else begin
      txd_r <= txd_bit_s;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboarded bench for uart_tx_fifo at DIV=10: stimulus queues expected bytes,
// a txd monitor checks every frame clock by clock against the queue head.
module tb_uart_tx_fifo;

  logic       clock = 1'b0;
  logic       reset;
  logic [7:0] data_in;
  logic       data_valid;
  logic       data_ready;
  logic       rewind;
  logic       txd;
  logic       busy;
  logic [4:0] fifo_count;

  int n_checks = 0;
  int n_fail   = 0;
  int n_frames = 0;
  logic [7:0] exp_q [$];

  always #5 clock = ~clock;

  uart_tx_fifo #(
    .clock_freq (10),
    .baud_rate  (1),
    .depth_log2 (4)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .data_in    (data_in),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .rewind     (rewind),
    .txd        (txd),
    .busy       (busy),
    .fifo_count (fifo_count)
  );

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  function automatic logic [7:0] burst_byte(input int i);
    return 8'(i * 29 + 7);
  endfunction

  function automatic logic [7:0] wrap_byte(input int i);
    return 8'(i * 13 + 100);
  endfunction

  // Offer one byte aligned to a clock, holding data_valid until data_ready accepts it.
  task automatic send(input logic [7:0] b);
    int   waited = 0;
    logic rdy    = 1'b0;
    @(posedge clock);
    #1;
    data_in    = b;
    data_valid = 1'b1;
    do begin
      @(negedge clock);
      rdy = data_ready;
      @(posedge clock);
      waited++;
    end while (!rdy && waited < 300);
    #1 data_valid = 1'b0;
    if (rdy) begin
      exp_q.push_back(b);
    end else begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: byte %0h not accepted, expected acceptance within 300 clocks", b);
    end
  endtask

  task automatic wait_idle(input int budget, output int cycles);
    cycles = 0;
    while (busy !== 1'b0 && cycles < budget) begin
      @(negedge clock);
      cycles++;
    end
  endtask

  // Monitor: each frame must be start, 8 data bits LSB first, stop, 10 clocks per bit.
  logic       mon_active = 1'b0;
  int         mon_pos    = 0;
  int         mon_skip   = 0;
  int         mon_bad_pos;
  logic [9:0] mon_frame;
  logic       mon_bad;
  logic       mon_bad_val;
  always @(negedge clock) begin
    int sel;
    if (reset || rewind) begin
      mon_active = 1'b0;
      mon_skip   = 0;
    end else if (mon_skip > 0) begin
      mon_skip--;
    end else begin
      if (!mon_active && txd === 1'b0) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_frame: start bit seen, expected idle line");
          mon_skip = 99;
        end else begin
          mon_frame  = {1'b1, exp_q.pop_front(), 1'b0};
          mon_active = 1'b1;
          mon_pos    = 0;
          mon_bad    = 1'b0;
        end
      end
      if (mon_active) begin
        sel = mon_pos / 10;
        if (txd !== mon_frame[sel] && !mon_bad) begin
          mon_bad     = 1'b1;
          mon_bad_pos = mon_pos;
          mon_bad_val = txd;
        end
        if (mon_pos == 99) begin
          n_checks++;
          n_frames++;
          if (mon_bad) begin
            n_fail++;
            $display("FAIL frame_%0h: txd=%b at clock %0d of frame, expected %b",
                     mon_frame[8:1], mon_bad_val, mon_bad_pos, mon_frame[mon_bad_pos / 10]);
          end
          mon_active = 1'b0;
        end else begin
          mon_pos++;
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc_n;
    reset      = 1'b1;
    data_valid = 1'b0;
    rewind     = 1'b0;
    data_in    = 8'h00;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("reset_txd", txd, 1);
    check("reset_count", fifo_count, 0);
    check("reset_busy", busy, 0);
    check("reset_ready", data_ready, 0);
    @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check("ready_after_reset", data_ready, 1);

    // Single byte 0xA5 into an idle block, written at edge N.
    @(posedge clock);
    #1;
    data_in    = 8'hA5;
    data_valid = 1'b1;
    exp_q.push_back(8'hA5);
    @(negedge clock);
    check("a5_ready", data_ready, 1);
    @(posedge clock);
    #1 data_valid = 1'b0;
    @(negedge clock);
    check("a5_count_n", fifo_count, 1);
    check("a5_busy_n", busy, 1);
    check("a5_txd_n", txd, 1);
    @(negedge clock);
    check("a5_popped_n1", fifo_count, 0);
    check("a5_txd_n1", txd, 1);
    @(negedge clock);
    check("a5_start_n2", txd, 0);
    repeat (98) @(negedge clock);
    check("a5_busy_n100", busy, 1);
    @(negedge clock);
    check("a5_busy_n101", busy, 0);
    check("a5_txd_idle", txd, 1);

    // 17-byte burst fills the FIFO behind frame 1; an 18th byte waits for a pop.
    @(posedge clock);
    #1 data_valid = 1'b1;
    for (int i = 0; i < 17; i++) begin
      data_in = burst_byte(i);
      exp_q.push_back(data_in);
      @(posedge clock);
      #1;
    end
    data_in = burst_byte(17);
    exp_q.push_back(data_in);
    @(negedge clock);
    check("burst_full_count", fifo_count, 16);
    check("burst_full_ready", data_ready, 0);
    repeat (84) @(negedge clock);
    check("burst_stall_count", fifo_count, 16);
    check("burst_stall_ready", data_ready, 0);
    @(negedge clock);
    check("burst_pop_count", fifo_count, 15);
    check("burst_pop_ready", data_ready, 1);
    @(posedge clock);
    #1 data_valid = 1'b0;
    @(negedge clock);
    check("burst_refill_count", fifo_count, 16);
    wait_idle(2000, cyc_n);
    check("burst_drain_cycles", cyc_n, 1699);

    // Push and pop on the same edge at fifo_count=3, then 40 bytes total through the wrap.
    @(posedge clock);
    #1 data_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      data_in = wrap_byte(i);
      exp_q.push_back(data_in);
      @(posedge clock);
      #1;
    end
    data_valid = 1'b0;
    @(negedge clock);
    check("wrap_count_3", fifo_count, 3);
    repeat (97) @(posedge clock);
    #1;
    data_in    = wrap_byte(4);
    data_valid = 1'b1;
    exp_q.push_back(data_in);
    @(negedge clock);
    check("wrap_pre_same_edge", fifo_count, 3);
    @(posedge clock);
    #1 data_valid = 1'b0;
    @(negedge clock);
    check("wrap_same_edge_count", fifo_count, 3);
    for (int i = 5; i < 40; i++) begin
      send(wrap_byte(i));
    end
    wait_idle(5000, cyc_n);
    check("wrap_drained", busy, 0);

    // Rewind during DATA bit 4 of frame 0xC0 with 5 bytes queued and a write offered.
    @(posedge clock);
    #1 data_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      data_in = 8'hC0 + 8'(i);
      exp_q.push_back(data_in);
      @(posedge clock);
      #1;
    end
    data_valid = 1'b0;
    @(negedge clock);
    check("rewind_queued", fifo_count, 5);
    repeat (49) @(posedge clock);
    #1;
    rewind     = 1'b1;
    data_valid = 1'b1;
    data_in    = 8'hEE;
    exp_q.delete();
    @(negedge clock);
    check("rewind_txd_bit4", txd, 0);
    check("rewind_ready_low", data_ready, 0);
    @(posedge clock);
    #1;
    rewind     = 1'b0;
    data_valid = 1'b0;
    @(negedge clock);
    check("rewind_txd", txd, 1);
    check("rewind_count", fifo_count, 0);
    check("rewind_busy", busy, 0);
    repeat (30) @(negedge clock);
    check("rewind_quiet", txd, 1);
    send(8'h3C);
    wait_idle(300, cyc_n);
    check("rewind_resume_idle", busy, 0);

    // Reset asserted during the START bit of 0x77 with 0x81 queued.
    @(posedge clock);
    #1;
    data_valid = 1'b1;
    data_in    = 8'h77;
    exp_q.push_back(data_in);
    @(posedge clock);
    #1;
    data_in = 8'h81;
    exp_q.push_back(data_in);
    @(posedge clock);
    #1 data_valid = 1'b0;
    @(negedge clock);
    check("reset_pre_count", fifo_count, 1);
    @(negedge clock);
    check("reset_pre_start", txd, 0);
    @(posedge clock);
    #1;
    reset = 1'b1;
    exp_q.delete();
    @(negedge clock);
    check("reset_ready_comb", data_ready, 0);
    @(negedge clock);
    check("midreset_txd", txd, 1);
    check("midreset_count", fifo_count, 0);
    check("midreset_ready", data_ready, 0);
    check("midreset_busy", busy, 0);
    repeat (2) @(negedge clock);
    @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check("release_ready", data_ready, 1);
    repeat (40) @(negedge clock);
    check("release_no_residual", txd, 1);
    send(8'h00);
    wait_idle(300, cyc_n);
    check("zero_byte_idle", busy, 0);

    repeat (3) @(negedge clock);
    check("frame_count", n_frames, 61);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
